fnd_scan_ctrl: RTL

FND_SCAN_CTRL -- requirements
Module: fnd_scan_ctrl

---
 rtl/fnd_scan_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fnd_scan_ctrl.sv
// Four-digit seven-segment scan controller for the watch display.
// Cycles one digit per scan tick and latches the displayed values once per
// frame so a digit never shows a mix of old and new time values.
module fnd_scan_ctrl #(
    parameter int unsigned SCAN_DIV = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel_mode,
    input  logic [6:0] msec,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [4:0] hour,
    output logic [3:0] fnd_com,
    output logic [7:0] fnd_data
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam int unsigned DIG_W = 4;

    logic [DIV_W-1:0] div_cnt;
    logic             scan_tick;
    logic [1:0]       idx;
    logic [1:0]       nx_idx;
    logic             frame_start;

    // Frame snapshot of the display sources
    logic             snap_mode;
    logic [6:0]       snap_msec;
    logic [5:0]       snap_sec;
    logic [5:0]       snap_min;
    logic [4:0]       snap_hour;

    // Snapshot as it will be after this edge (fresh values on a frame start)
    logic             nx_mode;
    logic [6:0]       nx_msec;
    logic [5:0]       nx_sec;
    logic [5:0]       nx_min;
    logic [4:0]       nx_hour;

    logic [6:0]       lo_val;
    logic [6:0]       hi_val;
    logic [DIG_W-1:0] digit;
    logic [6:0]       seg;
    logic             dp_n;

    // Active-low segment pattern g..a; anything above 9 is blanked
    function automatic logic [6:0] seg_code(input logic [DIG_W-1:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign scan_tick = (div_cnt == DIV_LAST);

    // Scan divider: free-running 0..SCAN_DIV-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (scan_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Next digit, next snapshot and the segment pattern for that digit
    always_comb begin
        frame_start = scan_tick && (idx == 2'd3);
        nx_idx      = idx + 2'd1;

        nx_mode = snap_mode;
        nx_msec = snap_msec;
        nx_sec  = snap_sec;
        nx_min  = snap_min;
        nx_hour = snap_hour;
        if (frame_start) begin
            nx_mode = sel_mode;
            nx_msec = msec;
            nx_sec  = sec;
            nx_min  = min;
            nx_hour = hour;
        end

        lo_val = nx_mode ? 7'(nx_min)  : nx_msec;
        hi_val = nx_mode ? 7'(nx_hour) : 7'(nx_sec);

        digit = '0;
        case (nx_idx)
            2'd0:    digit = DIG_W'(lo_val % 7'd10);
            2'd1:    digit = DIG_W'(lo_val / 7'd10);
            2'd2:    digit = DIG_W'(hi_val % 7'd10);
            default: digit = DIG_W'(hi_val / 7'd10);
        endcase

        seg  = seg_code(digit);
        dp_n = !((nx_idx == 2'd2) && (nx_msec < 7'd50));
    end

    // Digit index and per-frame snapshot registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= 2'd3;
            snap_mode <= 1'b0;
            snap_msec <= '0;
            snap_sec  <= '0;
            snap_min  <= '0;
            snap_hour <= '0;
        end else if (scan_tick) begin
            idx       <= nx_idx;
            snap_mode <= nx_mode;
            snap_msec <= nx_msec;
            snap_sec  <= nx_sec;
            snap_min  <= nx_min;
            snap_hour <= nx_hour;
        end
    end

    // Registered digit enable and segment outputs, refreshed once per tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fnd_com  <= 4'b1111;
            fnd_data <= 8'hFF;
        end else if (scan_tick) begin
            fnd_com  <= ~(4'b0001 << nx_idx);
            fnd_data <= {dp_n, seg};
        end
    end

endmodule
